two_ops_accum: RTL and testbench

//   Downstream consumer of the 8-bit add/sub datapath result (test_two_ops O).

---
 rtl/two_ops_accum.sv | 99 +++++++++
 tb/tb_two_ops_accum.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/two_ops_accum.sv
// Block accumulator: sums COUNT unsigned results arriving over valid/ready and
// presents each block sum with a sticky overflow flag through a one-entry hold register.
module two_ops_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned COUNT     = 4
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_valid,
    output logic                 I_ready,
    output logic [ACC_WIDTH-1:0] O,
    output logic                 O_ovf,
    output logic                 O_valid,
    input  logic                 O_ready
);

    localparam int unsigned CntW = $clog2(COUNT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

    generate
        if (ACC_WIDTH < WIDTH || COUNT < 1 || COUNT > 255) begin : g_bad_param
            $error("two_ops_accum: illegal WIDTH/ACC_WIDTH/COUNT combination");
        end
    endgenerate

    typedef enum logic [0:0] {StAccum, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   o_q, o_d;
    logic                   o_ovf_q, o_ovf_d;
    logic [ACC_WIDTH:0]     in_ext;
    logic [ACC_WIDTH:0]     sum_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        o_d     = o_q;
        o_ovf_d = o_ovf_q;
        // One extra bit catches the carry out of the accumulator.
        in_ext  = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, I};
        sum_ext = {1'b0, acc_q} + in_ext;

        unique case (state_q)
            StAccum: begin
                if (I_valid) begin
                    acc_d = sum_ext[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                    if (cnt_q == CntLast) begin
                        o_d     = acc_d;
                        o_ovf_d = ovf_d;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (O_ready) begin
                    ovf_d   = 1'b0;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            o_q     <= '0;
            o_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            o_q     <= o_d;
            o_ovf_q <= o_ovf_d;
        end
    end

    assign I_ready = (state_q == StAccum);
    assign O_valid = (state_q == StDrain);
    assign O       = o_q;
    assign O_ovf   = o_ovf_q;

endmodule

// File: tb/tb_two_ops_accum.sv
// Scoreboard bench for two_ops_accum: three configurations share one stimulus
// stream; a block-level model predicts sums, a negedge monitor checks outputs.
module tb_two_ops_accum;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    logic [2:0]  ir, ov, oovf;
    logic [15:0] o_a, o_c;
    logic [8:0]  o_b;
    logic [15:0] o_arr [3];

    always #5 clk = ~clk;

    // Lane 0: defaults; lane 1: 9-bit accumulator; lane 2: COUNT=1.
    two_ops_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) dut_a (
        .CLK(clk), .RESETN(rstn), .I(i_data), .I_valid(i_valid), .I_ready(ir[0]),
        .O(o_a), .O_ovf(oovf[0]), .O_valid(ov[0]), .O_ready(o_ready)
    );
    two_ops_accum #(.WIDTH(8), .ACC_WIDTH(9), .COUNT(4)) dut_b (
        .CLK(clk), .RESETN(rstn), .I(i_data), .I_valid(i_valid), .I_ready(ir[1]),
        .O(o_b), .O_ovf(oovf[1]), .O_valid(ov[1]), .O_ready(o_ready)
    );
    two_ops_accum #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(1)) dut_c (
        .CLK(clk), .RESETN(rstn), .I(i_data), .I_valid(i_valid), .I_ready(ir[2]),
        .O(o_c), .O_ovf(oovf[2]), .O_valid(ov[2]), .O_ready(o_ready)
    );

    assign o_arr[0] = o_a;
    assign o_arr[1] = {7'd0, o_b};
    assign o_arr[2] = o_c;

    typedef struct {
        int          lane;
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    bit          hold[3];
    bit          after_rst[3];
    int unsigned bsum[3];
    int unsigned bn[3];
    bit          started = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic int unsigned lane_aw(int l);
        return (l == 1) ? 9 : 16;
    endfunction

    function automatic int unsigned lane_cnt(int l);
        return (l == 2) ? 1 : 4;
    endfunction

    // Upstream add/sub datapath: (a + b) - a in 8-bit arithmetic.
    function automatic logic [7:0] datapath(logic [7:0] a, logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        return s - a;
    endfunction

    task automatic check(string name, int l, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s lane%0d: got %0d expected %0d", name, l, act, want);
        end
    endtask

    // Reference model: plain integer block sums, reduced modulo 2^aw at block end.
    always @(posedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if (!rstn) begin
                hold[l]      = 1'b0;
                bsum[l]      = 0;
                bn[l]        = 0;
                after_rst[l] = 1'b1;
            end else if (!hold[l] && i_valid) begin
                bsum[l] += i_data;
                bn[l]++;
                if (bn[l] == lane_cnt(l)) begin
                    exp_t e;
                    e.lane = l;
                    e.sum  = bsum[l] & ((32'd1 << lane_aw(l)) - 1);
                    e.ovf  = (bsum[l] >= (32'd1 << lane_aw(l)));
                    exp_q.push_back(e);
                    hold[l] = 1'b1;
                    bsum[l] = 0;
                    bn[l]   = 0;
                end
            end else if (hold[l] && o_ready) begin
                hold[l] = 1'b0;
            end
        end
        if (!rstn) started = 1'b1;
    end

    // Monitor: compares handshake outputs and pops the scoreboard on O transfers.
    always @(negedge clk) begin
        if (started) begin
            for (int l = 0; l < 3; l++) begin
                int idx;
                if (after_rst[l]) begin
                    check("reset_O", l, o_arr[l], 0);
                    check("reset_O_ovf", l, {31'd0, oovf[l]}, 0);
                    for (int k = exp_q.size() - 1; k >= 0; k--)
                        if (exp_q[k].lane == l) exp_q.delete(k);
                    after_rst[l] = 1'b0;
                end
                check("I_ready", l, {31'd0, ir[l]}, {31'd0, !hold[l]});
                check("O_valid", l, {31'd0, ov[l]}, {31'd0, hold[l]});
                if (ov[l] === 1'b1) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (idx < 0 && exp_q[k].lane == l) idx = k;
                    if (idx < 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_O lane%0d: got O=%0d with no block expected",
                                 l, o_arr[l]);
                    end else begin
                        check("O", l, o_arr[l], exp_q[idx].sum);
                        check("O_ovf", l, {31'd0, oovf[l]}, {31'd0, exp_q[idx].ovf});
                        if (o_ready) exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(int v, int gap);
        i_data  = 8'(v);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < gap; k++) tick();
    endtask

    initial begin
        rstn    = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        idle(3);
        rstn = 1'b1;

        // Back-to-back block with a free-running sink.
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        idle(3);

        // Sink stalled while I_valid keeps pulsing.
        o_ready = 1'b0;
        send(5, 0); send(6, 0); send(7, 0); send(8, 0);
        for (int k = 0; k < 5; k++) begin
            i_data  = 8'($urandom_range(0, 255));
            i_valid = 1'(k % 2);
            tick();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        idle(3);

        // Gaps between inputs.
        send(1, 2); send(2, 2); send(3, 2); send(4, 2);
        idle(2);

        // Overflow in the 9-bit lane, then a clean block clears the flag.
        send(200, 0); send(200, 0); send(200, 0); send(200, 0);
        idle(2);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        idle(2);

        // Reset with a partial block in flight.
        send(50, 0); send(60, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        idle(2);

        // Results from the upstream datapath.
        for (int k = 0; k < 8; k++) send(int'(datapath(8'd7, 8'd9)), 0);
        idle(3);

        // Randomized traffic with occasional resets and sink stalls.
        for (int k = 0; k < 3000; k++) begin
            i_data  = 8'($urandom_range(0, 255));
            i_valid = ($urandom_range(0, 3) != 0);
            o_ready = ($urandom_range(0, 3) != 0);
            rstn    = ($urandom_range(0, 299) != 0);
            tick();
        end

        rstn    = 1'b1;
        o_ready = 1'b1;
        idle(6);
        for (int l = 0; l < 3; l++) begin
            int left = 0;
            foreach (exp_q[k]) if (exp_q[k].lane == l) left++;
            check("undrained_blocks", l, left, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
